store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-store queue between the MEM-stage store path and the data memory's write port.
- Accepts word/half/byte stores from the pipeline, checks alignment and generates the 4-bit byte enable.
- Drains entries in order to the data memory, one per cycle.
- Flags loads that hit a still-pending store word so the hazard unit can stall until the data memory is coherent.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- st_valid  in  1  store request from MEM stage.
- st_type  in  2  00 = word (sw), 01 = half (sh), 10 = byte (sb), 11 = reserved.
- st_addr  in  32  byte address of store.
- st_data  in  32  raw rt value; low bits hold the half or byte.
- st_pc4  in  32  PC+4 of the store instruction.
- st_ready  out  1  queue can accept a store this cycle.
- st_err  out  1  one-cycle pulse: store rejected for misalignment or reserved type.
- ld_valid  in  1  load in MEM stage this cycle.
- ld_addr  in  32  load byte address.
- ld_hazard  out  1  load word matches a pending entry.
- drain_hold  in  1  suppress draining this cycle.
- dm_we  out  1  write strobe to data memory.
- dm_addr  out  32  address to data memory.
- dm_wd  out  32  write data to data memory (raw st_data).
- dm_be  out  4  byte enable to data memory.
- dm_pc4  out  32  PC+4 forwarded for write trace.
- sb_empty  out  1  queue empty.
- sb_count  out  PTR_W+1  occupancy.

Behaviour:
- Storage:
  - Circular FIFO of DEPTH entries {addr, data, be, pc4}.
  - Write pointer, read pointer and count registers.
- Reset:
  - wr_ptr = 0, rd_ptr = 0, count = 0, st_err = 0.
  - Entry contents are don't-care.
  - Outputs during reset cycle and after: dm_we = 0, sb_empty = 1, sb_count = 0, st_ready = 1, ld_hazard = 0.
  - A reset during any operation discards all pending entries; no dm_we is issued in the reset cycle.
- Byte-enable generation (registered into the entry at push):
  - Word: 1111.
  - Half: addr[1] = 0 → 0011; addr[1] = 1 → 1100.
  - Byte: 0001 << addr[1:0].
- Alignment:
  - Word with addr[1:0] != 00, half with addr[0] = 1, or type 11 → not pushed.
  - In those cases st_err = 1 on the following cycle only.
  - st_err is a registered pulse.
- Push: occurs at posedge when st_valid && st_ready && aligned && !reset.
- st_ready:
  - st_ready = (count != DEPTH), combinational.
  - No push-while-full even if a pop occurs in the same cycle.
  - st_valid with st_ready = 0: no push and no error; the pipeline is responsible for stalling.
- Drain:
  - dm_we = !sb_empty && !drain_hold, combinational from the head entry.
  - dm_addr, dm_wd, dm_be, dm_pc4 = head fields.
  - Pop at the same posedge as dm_we = 1.
  - A store pushed at edge N appears on dm_we during cycle N+1 at the earliest and is written to memory at edge N+1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap: modulo DEPTH.
- Ordering:
  - Strict FIFO; entries are never merged or reordered.
  - Back-to-back stores to the same word drain in issue order.
- ld_hazard:
  - Combinational: ld_valid && (any valid entry has addr[31:2] == ld_addr[31:2]).
  - The head entry being popped this cycle still counts.
  - An incoming store in the same cycle is not compared; st_valid and ld_valid are mutually exclusive by pipeline construction.
  - If both are asserted, the store is processed normally.
- Valid-entry mask: derived from rd_ptr and count, not stored per-entry valid bits.
- sb_empty = (count == 0); sb_count = count.

Optional Feature:
- Macro: SB_STORE_FWD_EN.
- Defined:
  - If the youngest matching pending entry has be = 1111 and ld_addr[31:2] matches, ld_hazard = 0.
  - A new output ld_fwd_valid = 1, and ld_fwd_data (32) = that entry's data.
  - Matches with partial be still assert ld_hazard.
- Not defined:
  - ld_fwd_valid and ld_fwd_data are absent.
  - Every match asserts ld_hazard.

Test Plan:
- Reset, then sw addr 0x0000_0010, data 0xDEADBEEF → next cycle dm_we = 1, dm_addr = 0x10, dm_be = 1111, dm_wd = 0xDEADBEEF; then sb_empty = 1.
- sh to 0x22 data 0x0000_1234, then sb to 0x23 data 0x56 → drain order be = 1100 then be = 1000, addresses 0x22 then 0x23.
- drain_hold = 1, push 4 stores → sb_count = 4, st_ready = 0. Fifth st_valid is ignored, st_err = 0. Release hold → four drains on consecutive cycles, pointers wrap, count returns to 0.
- sw to 0x13 → no push, st_err pulses for exactly 1 cycle. sh to 0x11 → same response.
- Pending sw at 0x40, ld_addr 0x42 → ld_hazard = 1; ld_addr 0x44 → ld_hazard = 0. With SB_STORE_FWD_EN defined, ld_addr 0x40 → ld_hazard = 0, ld_fwd_data = stored word.
- Push 3 stores with hold, assert reset one cycle → sb_count = 0 and dm_we = 0 thereafter; no writes issued.

Source files
------------

// File: rtl/store_buffer_if.sv
// Store buffer port bundle: MEM-stage store/load side, drain side, status.
// SB_STORE_FWD_EN adds the full-word load forwarding outputs.
interface store_buffer_if #(
    parameter int PTR_W = 2
);
    logic             st_valid;
    logic [1:0]       st_type;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [31:0]      st_pc4;
    logic             st_ready;
    logic             st_err;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic             ld_hazard;
    logic             drain_hold;
    logic             dm_we;
    logic [31:0]      dm_addr;
    logic [31:0]      dm_wd;
    logic [3:0]       dm_be;
    logic [31:0]      dm_pc4;
    logic             sb_empty;
    logic [PTR_W:0]   sb_count;
`ifdef SB_STORE_FWD_EN
    logic             ld_fwd_valid;
    logic [31:0]      ld_fwd_data;

    modport master (
        output st_valid, st_type, st_addr, st_data, st_pc4,
        output ld_valid, ld_addr, drain_hold,
        input  st_ready, st_err, ld_hazard,
        input  dm_we, dm_addr, dm_wd, dm_be, dm_pc4,
        input  sb_empty, sb_count,
        input  ld_fwd_valid, ld_fwd_data
    );

    modport slave (
        input  st_valid, st_type, st_addr, st_data, st_pc4,
        input  ld_valid, ld_addr, drain_hold,
        output st_ready, st_err, ld_hazard,
        output dm_we, dm_addr, dm_wd, dm_be, dm_pc4,
        output sb_empty, sb_count,
        output ld_fwd_valid, ld_fwd_data
    );
`else
    modport master (
        output st_valid, st_type, st_addr, st_data, st_pc4,
        output ld_valid, ld_addr, drain_hold,
        input  st_ready, st_err, ld_hazard,
        input  dm_we, dm_addr, dm_wd, dm_be, dm_pc4,
        input  sb_empty, sb_count
    );

    modport slave (
        input  st_valid, st_type, st_addr, st_data, st_pc4,
        input  ld_valid, ld_addr, drain_hold,
        output st_ready, st_err, ld_hazard,
        output dm_we, dm_addr, dm_wd, dm_be, dm_pc4,
        output sb_empty, sb_count
    );
`endif
endinterface

// File: rtl/store_buffer.sv
// In-order posted-store queue in front of the data memory write port.
// SB_STORE_FWD_EN: forward youngest full-word match to loads instead of stalling.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
);

    logic [31:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [31:0]      r_pc4  [DEPTH];
    logic [3:0]       r_be   [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_st_err;

    logic [3:0]       w_be;
    logic             w_aligned;
    logic             w_empty;
    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_err;
    logic             w_match;
    logic [PTR_W-1:0] w_idx;
`ifdef SB_STORE_FWD_EN
    logic             w_young_full;
    logic [31:0]      w_young_data;
`endif

    always_comb begin
        w_be      = 4'b0000;
        w_aligned = 1'b0;
        unique case (sb.st_type)
            2'b00: begin
                w_be      = 4'b1111;
                w_aligned = (sb.st_addr[1:0] == 2'b00);
            end
            2'b01: begin
                w_be      = sb.st_addr[1] ? 4'b1100 : 4'b0011;
                w_aligned = !sb.st_addr[0];
            end
            2'b10: begin
                w_be      = 4'b0001 << sb.st_addr[1:0];
                w_aligned = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_empty = (r_count == '0);
    assign w_ready = (r_count != (PTR_W+1)'(DEPTH));
    assign w_push  = sb.st_valid && w_ready && w_aligned;
    assign w_err   = sb.st_valid && w_ready && !w_aligned;
    assign w_pop   = !w_empty && !sb.drain_hold && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_st_err <= 1'b0;
        end else begin
            r_st_err <= w_err;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    // Entry payload needs no reset; validity comes from rd_ptr/count.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_addr[r_wr_ptr] <= sb.st_addr;
            r_data[r_wr_ptr] <= sb.st_data;
            r_pc4[r_wr_ptr]  <= sb.st_pc4;
            r_be[r_wr_ptr]   <= w_be;
        end
    end

    // Walk oldest to youngest so the last hit is the youngest match.
    always_comb begin
        w_match = 1'b0;
        w_idx   = '0;
`ifdef SB_STORE_FWD_EN
        w_young_full = 1'b0;
        w_young_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + PTR_W'(i);
            if (((PTR_W+1)'(i) < r_count) &&
                (r_addr[w_idx][31:2] == sb.ld_addr[31:2])) begin
                w_match = 1'b1;
`ifdef SB_STORE_FWD_EN
                w_young_full = (r_be[w_idx] == 4'b1111);
                w_young_data = r_data[w_idx];
`endif
            end
        end
    end

`ifdef SB_STORE_FWD_EN
    assign sb.ld_hazard    = sb.ld_valid && w_match && !w_young_full && !reset;
    assign sb.ld_fwd_valid = sb.ld_valid && w_match && w_young_full && !reset;
    assign sb.ld_fwd_data  = w_young_data;
`else
    assign sb.ld_hazard    = sb.ld_valid && w_match && !reset;
`endif

    assign sb.st_ready = w_ready || reset;
    assign sb.st_err   = r_st_err && !reset;
    assign sb.sb_empty = w_empty || reset;
    assign sb.sb_count = reset ? '0 : r_count;
    assign sb.dm_we    = w_pop;
    assign sb.dm_addr  = r_addr[r_rd_ptr];
    assign sb.dm_wd    = r_data[r_rd_ptr];
    assign sb.dm_be    = r_be[r_rd_ptr];
    assign sb.dm_pc4   = r_pc4[r_rd_ptr];

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer against a queue-based reference model.
// Directed test-plan sequences first, then random traffic.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] pc4;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    ent_t q[$];
    logic m_err = 1'b0;

    store_buffer_if #(.PTR_W(PTR_W)) sb();

    store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_aligned(input logic [1:0] t, input logic [31:0] a);
        case (t)
            2'd0:    return (a % 4) == 0;
            2'd1:    return (a % 2) == 0;
            2'd2:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] be_of(input logic [1:0] t, input logic [31:0] a);
        case (t)
            2'd0:    return 4'hF;
            2'd1:    return ((a % 4) >= 2) ? 4'hC : 4'h3;
            default: return 4'(1 << (a % 4));
        endcase
    endfunction

    // Drive one cycle, compare outputs against the model, then advance the model.
    task automatic step(input logic rst, input logic sv, input logic [1:0] st,
                        input logic [31:0] sa, input logic [31:0] sd,
                        input logic [31:0] sp, input logic lv,
                        input logic [31:0] la, input logic hold);
        logic e_we, e_haz, found, full, rdy, ok;
        logic [31:0] fdata;
        int n;
        @(negedge clk);
        reset         = rst;
        sb.st_valid   = sv;
        sb.st_type    = st;
        sb.st_addr    = sa;
        sb.st_data    = sd;
        sb.st_pc4     = sp;
        sb.ld_valid   = lv;
        sb.ld_addr    = la;
        sb.drain_hold = hold;
        #1;
        n = rst ? 0 : q.size();
        e_we = (n > 0) && !hold;
        found = 1'b0;
        full  = 1'b0;
        fdata = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!found && (q[i].addr / 4) == (la / 4)) begin
                found = 1'b1;
                full  = (q[i].be == 4'hF);
                fdata = q[i].data;
            end
        end
`ifdef SB_STORE_FWD_EN
        e_haz = lv && found && !full;
        check("fwd_valid", 32'(sb.ld_fwd_valid), 32'(lv && found && full));
        if (lv && found && full)
            check("fwd_data", sb.ld_fwd_data, fdata);
`else
        e_haz = lv && found;
`endif
        check("st_ready", 32'(sb.st_ready), 32'(n != DEPTH));
        check("sb_empty", 32'(sb.sb_empty), 32'(n == 0));
        check("sb_count", 32'(sb.sb_count), 32'(n));
        check("st_err", 32'(sb.st_err), 32'(m_err && !rst));
        check("ld_hazard", 32'(sb.ld_hazard), 32'(e_haz));
        check("dm_we", 32'(sb.dm_we), 32'(e_we));
        if (e_we) begin
            check("dm_addr", sb.dm_addr, q[0].addr);
            check("dm_wd", sb.dm_wd, q[0].data);
            check("dm_be", 32'(sb.dm_be), 32'(q[0].be));
            check("dm_pc4", sb.dm_pc4, q[0].pc4);
        end
        if (rst) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            rdy = (q.size() != DEPTH);
            ok  = is_aligned(st, sa);
            if (e_we)
                void'(q.pop_front());
            if (sv && rdy && ok)
                q.push_back('{addr: sa, data: sd, be: be_of(st, sa), pc4: sp});
            m_err = sv && rdy && !ok;
        end
    endtask

    task automatic idle(input logic hold);
        step(1'b0, 1'b0, 2'd0, '0, '0, '0, 1'b0, '0, hold);
    endtask

    task automatic store(input logic [1:0] t, input logic [31:0] a,
                         input logic [31:0] d, input logic hold);
        step(1'b0, 1'b1, t, a, d, a + 32'h1000, 1'b0, '0, hold);
    endtask

    task automatic load(input logic [31:0] a, input logic hold);
        step(1'b0, 1'b0, 2'd0, '0, '0, '0, 1'b1, a, hold);
    endtask

    initial begin
        reset         = 1'b1;
        sb.st_valid   = 1'b0;
        sb.st_type    = '0;
        sb.st_addr    = '0;
        sb.st_data    = '0;
        sb.st_pc4     = '0;
        sb.ld_valid   = 1'b0;
        sb.ld_addr    = '0;
        sb.drain_hold = 1'b0;

        step(1'b1, 1'b0, 2'd0, '0, '0, '0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 2'd0, '0, '0, '0, 1'b0, '0, 1'b0);

        store(2'd0, 32'h10, 32'hDEADBEEF, 1'b0);
        idle(1'b0);
        check("sw_we", 32'(sb.dm_we), 32'd1);
        check("sw_addr", sb.dm_addr, 32'h10);
        check("sw_be", 32'(sb.dm_be), 32'hF);
        check("sw_wd", sb.dm_wd, 32'hDEADBEEF);
        idle(1'b0);
        check("sw_empty", 32'(sb.sb_empty), 32'd1);

        store(2'd1, 32'h22, 32'h1234, 1'b0);
        store(2'd2, 32'h23, 32'h56, 1'b0);
        check("sh_be", 32'(sb.dm_be), 32'hC);
        check("sh_addr", sb.dm_addr, 32'h22);
        idle(1'b0);
        check("sb_be", 32'(sb.dm_be), 32'h8);
        check("sb_addr", sb.dm_addr, 32'h23);

        for (int k = 0; k < 4; k++)
            store(2'd0, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k), 1'b1);
        store(2'd0, 32'h200, 32'hBAD, 1'b1);
        check("full_cnt", 32'(sb.sb_count), 32'd4);
        check("full_rdy", 32'(sb.st_ready), 32'd0);
        idle(1'b1);
        check("full_noerr", 32'(sb.st_err), 32'd0);
        for (int k = 0; k < 4; k++)
            idle(1'b0);
        idle(1'b0);
        check("drain_empty", 32'(sb.sb_count), 32'd0);

        store(2'd0, 32'h13, 32'h1, 1'b0);
        idle(1'b0);
        check("sw_mis_err", 32'(sb.st_err), 32'd1);
        idle(1'b0);
        check("sw_mis_pulse", 32'(sb.st_err), 32'd0);
        store(2'd1, 32'h11, 32'h2, 1'b0);
        idle(1'b0);
        check("sh_mis_err", 32'(sb.st_err), 32'd1);
        check("sh_mis_cnt", 32'(sb.sb_count), 32'd0);
        idle(1'b0);
        check("sh_mis_pulse", 32'(sb.st_err), 32'd0);

        store(2'd0, 32'h40, 32'hCAFEF00D, 1'b1);
        load(32'h44, 1'b1);
        check("haz_miss", 32'(sb.ld_hazard), 32'd0);
`ifdef SB_STORE_FWD_EN
        load(32'h40, 1'b1);
        check("fwd_haz", 32'(sb.ld_hazard), 32'd0);
        check("fwd_word", sb.ld_fwd_data, 32'hCAFEF00D);
`else
        load(32'h42, 1'b1);
        check("haz_hit", 32'(sb.ld_hazard), 32'd1);
`endif
        idle(1'b0);

        for (int k = 0; k < 3; k++)
            store(2'd0, 32'h80 + 32'(4 * k), 32'h5 + 32'(k), 1'b1);
        step(1'b1, 1'b0, 2'd0, '0, '0, '0, 1'b0, '0, 1'b1);
        idle(1'b1);
        check("rst_cnt", 32'(sb.sb_count), 32'd0);
        idle(1'b0);
        check("rst_nowe", 32'(sb.dm_we), 32'd0);

        for (int k = 0; k < 3000; k++) begin
            logic [31:0] sa;
            sa = 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 3) == 0)
                sa = sa + 32'($urandom_range(0, 3));
            step($urandom_range(0, 99) == 0, 1'($urandom),
                 2'($urandom), sa, $urandom, $urandom,
                 1'($urandom), 32'($urandom_range(0, 63)),
                 $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
